// File: rtl/func_seq_alu_hs.sv
// Handshaked sequential ALU for a CGRA processing element: single-cycle ops plus iterative sdiv.
// Optional err output enabled by defining FUNC_SEQ_ALU_ERR_FLAGS_EN.
module func_seq_alu_hs #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    input  logic [3:0]      select,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE-1:0] out,
    output logic            out_valid,
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
    output logic [1:0]      err,
`endif
    input  logic            out_ready
);

    localparam int unsigned SHW = $clog2(SIZE);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpMul  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSdiv = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpShl  = 4'd7;
    localparam logic [3:0] OpAshr = 4'd8;
    localparam logic [3:0] OpLshr = 4'd9;

    typedef enum logic [0:0] {StIdle, StDiv} state_e;

    state_e          state_q;
    logic [SHW-1:0]  cnt_q;
    logic [SIZE-1:0] quo_q, rem_q, div_q;
    logic            neg_q, dz_q;
    logic [SIZE-1:0] out_q;
    logic            out_valid_q;
    logic [1:0]      err_q;

    logic            accept;
    logic [SIZE-1:0] alu_res;
    logic            illegal;
    logic [SHW-1:0]  shamt;
    logic [SIZE:0]   trial;
    logic [SIZE-1:0] quo_d, rem_d, div_res;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
    assign err       = err_q;
`endif
    assign shamt     = in_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        illegal = 1'b0;
        case (select)
            OpAdd:   alu_res = in_a + in_b;
            OpMul:   alu_res = in_a * in_b;
            OpSub:   alu_res = in_a - in_b;
            OpAnd:   alu_res = in_a & in_b;
            OpOr:    alu_res = in_a | in_b;
            OpXor:   alu_res = in_a ^ in_b;
            OpShl:   alu_res = in_a << shamt;
            OpAshr:  alu_res = $signed(in_a) >>> shamt;
            OpLshr:  alu_res = in_a >> shamt;
            OpSdiv:  alu_res = '0;
            default: illegal = 1'b1;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try subtracting.
    always_comb begin
        trial = {rem_q, quo_q[SIZE-1]} - {1'b0, div_q};
        if (!trial[SIZE]) begin
            rem_d = trial[SIZE-1:0];
            quo_d = {quo_q[SIZE-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[SIZE-2:0], quo_q[SIZE-1]};
            quo_d = {quo_q[SIZE-2:0], 1'b0};
        end
        if (dz_q) begin
            div_res = '1;
        end else if (neg_q) begin
            div_res = -quo_d;
        end else begin
            div_res = quo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (select == OpSdiv) begin
                            state_q <= StDiv;
                            cnt_q   <= '0;
                            quo_q   <= in_a[SIZE-1] ? -in_a : in_a;
                            div_q   <= in_b[SIZE-1] ? -in_b : in_b;
                            rem_q   <= '0;
                            neg_q   <= in_a[SIZE-1] ^ in_b[SIZE-1];
                            dz_q    <= (in_b == '0);
                        end else begin
                            out_q       <= alu_res;
                            out_valid_q <= 1'b1;
                            err_q       <= {illegal, 1'b0};
                        end
                    end
                end
                StDiv: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Accept only happened with the output slot free or draining, so it is free now.
                    if (cnt_q == SHW'(SIZE - 1)) begin
                        state_q     <= StIdle;
                        out_q       <= div_res;
                        out_valid_q <= 1'b1;
                        err_q       <= {1'b0, dz_q};
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_func_seq_alu_hs.sv
// Scoreboard bench for func_seq_alu_hs: stimulus pushes expected results, a monitor pops on delivery.
module tb_func_seq_alu_hs;

    localparam int unsigned SIZE = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [SIZE-1:0] in_a, in_b;
    logic [3:0]      select;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] dout;
    logic            out_valid;
    logic            out_ready;
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
    logic [1:0]      err;
`endif

    func_seq_alu_hs #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .select    (select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
        .err       (err),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a result is delivered when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got 0x%08h expected no result", dout);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_data"}, dout, mon_e.data);
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
                check({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
`endif
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic [1:0] exp_e, input string name,
                         input bit expect_now);
        int waits = 0;
        bit acc   = 1'b0;
        select   = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!acc && waits < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back('{exp_d, exp_e, name});
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: got no accept expected accept", name);
        end else if (expect_now) begin
            check({name, "_accept_wait"}, 32'(waits), 32'd0);
        end
    endtask

    task automatic issue_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                             input logic [1:0] exp_e, input string name);
        int bad = 0;
        issue(4'd3, a, b, exp_d, exp_e, name, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check({name, "_busy_cycles"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({name, "_latency_valid"}, 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        select    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", dout, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef FUNC_SEQ_ALU_ERR_FLAGS_EN
        check("reset_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops, one per cycle.
        issue(4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 2'b00, "add", 1'b1);
        issue(4'd6, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 2'b00, "xor", 1'b1);
        issue(4'd7, 32'h0000_0001, 32'd33, 32'h0000_0002, 2'b00, "shl_b33", 1'b1);
        @(negedge clk);
        check("shl_latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure holds the result, then same-cycle drain and accept.
        out_ready = 1'b0;
        issue(4'd1, 32'd7, 32'd6, 32'd42, 2'b00, "mul", 1'b1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (dout !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check("mul_backpressure_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        issue(4'd4, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 2'b00, "and_drain", 1'b1);

        issue_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 2'b00, "sdiv_m7_2");
        issue_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, "sdiv_min_m1");
        issue_div(32'd5, 32'd0, 32'hFFFF_FFFF, 2'b01, "sdiv_by0");

        // Reset during iteration 10 aborts the divide.
        issue(4'd3, 32'd100, 32'd3, 32'd33, 2'b00, "sdiv_abort", 1'b1);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out", dout, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (40) begin
            @(posedge clk);
            #1;
        end

        issue(4'd12, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 2'b10, "illegal12", 1'b1);
        issue(4'd8, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 2'b00, "ashr31", 1'b1);
        issue(4'd9, 32'h8000_0000, 32'd31, 32'h0000_0001, 2'b00, "lshr31", 1'b1);
        issue(4'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 2'b00, "sub", 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
